led_bus_arbiter: RTL

LED_BUS_ARBITER -- requirements
Module: led_bus_arbiter

---
 rtl/led_bus_if.sv | 34 +++
 rtl/led_bus_arbiter.sv | 88 ++++++++
 2 files changed

// File: rtl/led_bus_if.sv
// led_bus_if: requester-side and device-side signals of the shared LED bus
interface led_bus_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8
);
  logic [NUM_MASTERS-1:0]                 m_cyc_i;
  logic [NUM_MASTERS-1:0]                 m_stb_i;
  logic [NUM_MASTERS-1:0]                 m_we_i;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_dat_i;
  logic [NUM_MASTERS-1:0]                 m_ack_o;
  logic [NUM_MASTERS-1:0]                 m_err_o;
  logic [NUM_MASTERS-1:0]                 m_stall_o;
  logic                                   s_cyc_o;
  logic                                   s_stb_o;
  logic                                   s_we_o;
  logic [ADDR_WIDTH-1:0]                  s_adr_o;
  logic [DATA_WIDTH-1:0]                  s_dat_o;
  logic                                   s_ack_i;
  logic                                   s_err_i;
  logic                                   s_stall_i;
  logic [NUM_MASTERS-1:0]                 grant_o;
  // arbiter view
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_ack_i, s_err_i, s_stall_i,
    output m_ack_o, m_err_o, m_stall_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, grant_o
  );
  // requesters plus device view
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_ack_i, s_err_i, s_stall_i,
    input  m_ack_o, m_err_o, m_stall_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, grant_o
  );
endinterface

// File: rtl/led_bus_arbiter.sv
// led_bus_arbiter: round-robin arbiter sharing one LED device bus with a strobe watchdog
module led_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic     clk_i,
  input logic     rst_ni,
  led_bus_if.slave bus
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, OWNED, FLUSH} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, pick;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [NUM_MASTERS-1:0] oh;
  logic owned, cyc_own, stb_own, stalled, expire;
  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    return IW'(s >= NUM_MASTERS ? s - NUM_MASTERS : s);
  endfunction
  assign owned   = state_q == OWNED;
  assign cyc_own = bus.m_cyc_i[owner_q];
  assign stb_own = bus.m_stb_i[owner_q];
  assign oh      = NUM_MASTERS'(1) << owner_q;
  // a strobe waiting on the device with no response this cycle
  assign stalled = owned && stb_own && !bus.s_ack_i && !bus.s_err_i;
  // expiry lands on the TIMEOUT_CYCLES-th consecutive waiting cycle; a device response that cycle wins
  assign expire  = stalled && wdog_q == WW'(TIMEOUT_CYCLES - 1);
  // first requester at or after the priority pointer; reverse scan so the nearest one wins
  always_comb begin
    pick = ptr_q;
    for (int k = NUM_MASTERS - 1; k >= 0; k--)
      if (bus.m_cyc_i[wrap(ptr_q, k)]) pick = wrap(ptr_q, k);
  end
  // state, owner, pointer and watchdog registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end
  // next state: grant from IDLE, hold until release, divert to FLUSH on timeout
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    wdog_d  = stalled && !expire ? wdog_q + 1'b1 : '0;
    case (state_q)
      IDLE: if (|bus.m_cyc_i) begin
        state_d = OWNED;
        owner_d = pick;
      end
      OWNED: if (expire) state_d = FLUSH;
        else if (!cyc_own) begin
          state_d = IDLE;
          ptr_d   = wrap(owner_q, 1);
        end
      FLUSH: if (!cyc_own) begin
        state_d = IDLE;
        ptr_d   = wrap(owner_q, 1);
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs: owner passthrough while OWNED, everyone else stalled with no responses
  always_comb begin
    bus.grant_o   = state_q != IDLE ? oh : '0;
    bus.s_cyc_o   = owned;
    bus.s_stb_o   = owned && stb_own;
    bus.s_we_o    = owned && bus.m_we_i[owner_q];
    bus.s_adr_o   = owned ? bus.m_adr_i[owner_q] : '0;
    bus.s_dat_o   = owned ? bus.m_dat_i[owner_q] : '0;
    bus.m_ack_o   = owned && bus.s_ack_i ? oh : '0;
    bus.m_err_o   = owned && (bus.s_err_i || expire) ? oh : '0;
    bus.m_stall_o = !rst_ni ? '1 : owned && !bus.s_stall_i ? ~oh : '1;
  end
endmodule
